// File: rtl/dcache_lane_sequencer_pkg.sv
// Shared memory-pipeline types for the dcache lane sequencer: instruction,
// thread, scalar/vector data, pipeline select, memory access types, and
// predicates that classify access types.
package dcache_lane_sequencer_pkg;

`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

  localparam int NUM_LANES  = `VECTOR_LANES;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);

  typedef logic [31:0] scalar_t;
  typedef scalar_t [NUM_LANES-1:0] vector_t;
  typedef logic [1:0] thread_idx_t;

  typedef enum logic [1:0] {
    PIPE_MEM,
    PIPE_INT_ARITH,
    PIPE_FLOAT_ARITH
  } pipeline_sel_t;

  typedef enum logic [3:0] {
    MEM_B,
    MEM_BX,
    MEM_S,
    MEM_SX,
    MEM_L,
    MEM_SYNC,
    MEM_CONTROL_REG,
    MEM_BLOCK_VECTOR,
    MEM_BLOCK_VECTOR_M,
    MEM_STRIDED,
    MEM_STRIDED_M,
    MEM_STRIDED_IM,
    MEM_SCGATH,
    MEM_SCGATH_M,
    MEM_SCGATH_IM
  } memory_op_t;

  typedef struct packed {
    logic       is_memory_access;
    logic       is_load;
    memory_op_t memory_access_type;
    logic [5:0] dest_reg;
  } decoded_instruction_t;

  // Sequencer FSM: IDLE passes ops through, SEQ walks the lanes of one op.
  typedef enum logic {
    IDLE,
    SEQ
  } lane_seq_state_t;

  // Ops that expand into one access per lane.
  function automatic logic is_sequenced_access(input memory_op_t op);
    return (op == MEM_STRIDED)  || (op == MEM_STRIDED_M) || (op == MEM_STRIDED_IM) ||
           (op == MEM_SCGATH)   || (op == MEM_SCGATH_M)  || (op == MEM_SCGATH_IM);
  endfunction

  function automatic logic is_strided_access(input memory_op_t op);
    return (op == MEM_STRIDED) || (op == MEM_STRIDED_M) || (op == MEM_STRIDED_IM);
  endfunction

  // Sequenced ops whose lane mask is meaningful (masked / inverse-masked forms).
  function automatic logic is_masked_access(input memory_op_t op);
    return (op == MEM_STRIDED_M) || (op == MEM_STRIDED_IM) ||
           (op == MEM_SCGATH_M)  || (op == MEM_SCGATH_IM);
  endfunction

endpackage

// File: rtl/dcache_lane_sequencer_lane_priority_select.sv
// Next-active-lane encoder: finds the lowest set mask bit at or above
// start_i and reports whether it is the highest set bit of the mask.
module lane_priority_select
  import dcache_lane_sequencer_pkg::*;
(
  input  logic [NUM_LANES-1:0]  mask_i,
  input  logic [LANE_IDX_W-1:0] start_i,
  output logic                  found_o,
  output logic [LANE_IDX_W-1:0] lane_o,
  output logic                  is_last_o
);

  // Scan from the top down so the lowest qualifying lane wins.
  always_comb begin
    found_o   = 1'b0;
    lane_o    = '0;
    is_last_o = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_i[i] && (i >= int'(start_i))) begin
        found_o = 1'b1;
        lane_o  = LANE_IDX_W'(i);
      end
    end
    if (found_o) begin
      is_last_o = ((mask_i >> lane_o) == NUM_LANES'(1));
    end
  end

endmodule

// File: rtl/dcache_lane_sequencer.sv
// Memory-pipeline stage ahead of the dcache tag/data stages. Scalar and
// block ops pass through one register stage; strided and scatter/gather ops
// are expanded into one per-lane access per cycle while upstream is held off.
// Optional macro DCACHE_SKIP_MASKED_LANES_EN: emit only active lanes.
//
// Handshake: an instruction is taken on a rising edge when
// of_instruction_valid_i && ls_ready_o; while ls_ready_o is low, upstream
// holds its inputs. The output side has no back-pressure: ls_instruction_valid_o
// marks one access per cycle.
module dcache_lane_sequencer
  import dcache_lane_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  of_instruction_valid_i,
  input  decoded_instruction_t  of_instruction_i,
  input  logic [NUM_LANES-1:0]  of_mask_value_i,
  input  thread_idx_t           of_thread_idx_i,
  input  scalar_t               of_base_addr_i,
  input  scalar_t               of_stride_i,
  input  vector_t               of_ptr_vector_i,
  input  vector_t               of_store_value_i,
  output logic                  ls_ready_o,
  output logic                  ls_instruction_valid_o,
  output decoded_instruction_t  ls_instruction_o,
  output logic [NUM_LANES-1:0]  ls_mask_value_o,
  output thread_idx_t           ls_thread_idx_o,
  output scalar_t               ls_request_addr_o,
  output vector_t               ls_store_value_o,
  output scalar_t               ls_lane_value_o,
  output logic [LANE_IDX_W-1:0] ls_lane_idx_o,
  output logic                  ls_last_lane_o,
  input  logic                  wb_rollback_en_i,
  input  thread_idx_t           wb_rollback_thread_idx_i,
  input  pipeline_sel_t         wb_source_pipeline_i,
  output logic                  dbg_seq_active_o
);

  lane_seq_state_t       state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_q, lane_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  decoded_instruction_t  instr_q, instr_d;
  logic [NUM_LANES-1:0]  mask_q, mask_d;
  thread_idx_t           thread_q, thread_d;
  scalar_t               addr_q, addr_d;
  scalar_t               stride_q, stride_d;
  vector_t               ptr_q, ptr_d;
  vector_t               store_q, store_d;

  logic rb_mem, abort_seq, drop_in, accept, in_seq, in_strided, seq_advance;

  assign rb_mem      = wb_rollback_en_i && (wb_source_pipeline_i == PIPE_MEM);
  assign abort_seq   = rb_mem && (state_q == SEQ) && (wb_rollback_thread_idx_i == thread_q);
  assign drop_in     = rb_mem && (of_thread_idx_i == wb_rollback_thread_idx_i);
  assign ls_ready_o  = (state_q == IDLE) || ((state_q == SEQ) && last_q);
  assign accept      = of_instruction_valid_i && ls_ready_o && !abort_seq && !drop_in;
  assign in_seq      = is_sequenced_access(of_instruction_i.memory_access_type);
  assign in_strided  = is_strided_access(of_instruction_i.memory_access_type);
  assign seq_advance = (state_q == SEQ) && !last_q && !abort_seq;

`ifdef DCACHE_SKIP_MASKED_LANES_EN
  scalar_t               base_q, base_d;
  logic [NUM_LANES-1:0]  emask_q, emask_d;
  logic [NUM_LANES-1:0]  in_emask, sel_mask;
  logic [LANE_IDX_W-1:0] sel_start, sel_lane;
  logic                  sel_found, sel_last;

  assign in_emask  = is_masked_access(of_instruction_i.memory_access_type) ?
                     of_mask_value_i : '1;
  // Mid-sequence, search above the current lane; otherwise search the new op.
  assign sel_mask  = seq_advance ? emask_q : in_emask;
  assign sel_start = seq_advance ? (lane_q + 1'b1) : '0;

  lane_priority_select u_lane_sel (
    .mask_i   (sel_mask),
    .start_i  (sel_start),
    .found_o  (sel_found),
    .lane_o   (sel_lane),
    .is_last_o(sel_last)
  );
`endif

  // Next-state and next-output selection: abort, advance lane, accept, or idle.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    valid_d  = 1'b0;
    last_d   = last_q;
    instr_d  = instr_q;
    mask_d   = mask_q;
    thread_d = thread_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    ptr_d    = ptr_q;
    store_d  = store_q;
`ifdef DCACHE_SKIP_MASKED_LANES_EN
    base_d   = base_q;
    emask_d  = emask_q;
`endif
    if (abort_seq) begin
      state_d = IDLE;
      lane_d  = '0;
      last_d  = 1'b0;
    end else if (seq_advance) begin
      valid_d = 1'b1;
`ifdef DCACHE_SKIP_MASKED_LANES_EN
      lane_d  = sel_lane;
      last_d  = sel_last;
      addr_d  = is_strided_access(instr_q.memory_access_type) ?
                base_q + stride_q * scalar_t'(sel_lane) : ptr_q[sel_lane];
`else
      lane_d  = lane_q + 1'b1;
      last_d  = (lane_q == LANE_IDX_W'(NUM_LANES - 2));
      // Stride accumulator wraps at 32 bits by construction.
      addr_d  = is_strided_access(instr_q.memory_access_type) ?
                addr_q + stride_q : ptr_q[lane_q + 1'b1];
`endif
    end else if (accept) begin
      instr_d  = of_instruction_i;
      mask_d   = of_mask_value_i;
      thread_d = of_thread_idx_i;
      store_d  = of_store_value_i;
      if (in_seq) begin
        stride_d = of_stride_i;
        ptr_d    = of_ptr_vector_i;
`ifdef DCACHE_SKIP_MASKED_LANES_EN
        base_d   = of_base_addr_i;
        emask_d  = in_emask;
        if (sel_found) begin
          state_d = SEQ;
          valid_d = 1'b1;
          lane_d  = sel_lane;
          last_d  = sel_last;
          addr_d  = in_strided ? of_base_addr_i + of_stride_i * scalar_t'(sel_lane) :
                                 of_ptr_vector_i[sel_lane];
        end else begin
          state_d = IDLE;
          lane_d  = '0;
          last_d  = 1'b0;
        end
`else
        state_d = SEQ;
        valid_d = 1'b1;
        lane_d  = '0;
        last_d  = (NUM_LANES == 1);
        addr_d  = in_strided ? of_base_addr_i : of_ptr_vector_i[0];
`endif
      end else begin
        state_d = IDLE;
        valid_d = 1'b1;
        lane_d  = '0;
        last_d  = 1'b1;
        addr_d  = of_base_addr_i;
      end
    end else begin
      state_d = IDLE;
      lane_d  = '0;
      last_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      instr_q  <= '0;
      mask_q   <= '0;
      thread_q <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      ptr_q    <= '0;
      store_q  <= '0;
`ifdef DCACHE_SKIP_MASKED_LANES_EN
      base_q   <= '0;
      emask_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      instr_q  <= instr_d;
      mask_q   <= mask_d;
      thread_q <= thread_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      ptr_q    <= ptr_d;
      store_q  <= store_d;
`ifdef DCACHE_SKIP_MASKED_LANES_EN
      base_q   <= base_d;
      emask_q  <= emask_d;
`endif
    end
  end

  assign ls_instruction_valid_o = valid_q;
  assign ls_instruction_o       = instr_q;
  assign ls_mask_value_o        = mask_q;
  assign ls_thread_idx_o        = thread_q;
  assign ls_request_addr_o      = addr_q;
  assign ls_store_value_o       = store_q;
  assign ls_lane_value_o        = store_q[lane_q];
  assign ls_lane_idx_o          = lane_q;
  assign ls_last_lane_o         = last_q;
  assign dbg_seq_active_o       = (state_q == SEQ);

endmodule

// File: tb/tb_dcache_lane_sequencer.sv
// Self-checking bench for dcache_lane_sequencer: directed cases plus
// randomized instructions and rollbacks, checked against a lane-list model.
module tb_dcache_lane_sequencer;
  import dcache_lane_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  of_valid;
  decoded_instruction_t  of_instr;
  logic [NUM_LANES-1:0]  of_mask;
  thread_idx_t           of_thread;
  scalar_t               of_base, of_stride;
  vector_t               of_ptr, of_store;
  logic                  wb_en;
  thread_idx_t           wb_thr;
  pipeline_sel_t         wb_src;

  logic                  ls_ready, ls_valid, ls_last, dbg_seq;
  decoded_instruction_t  ls_instr;
  logic [NUM_LANES-1:0]  ls_mask;
  thread_idx_t           ls_thread;
  scalar_t               ls_addr, ls_lane_value;
  vector_t               ls_store;
  logic [LANE_IDX_W-1:0] ls_lane_idx;

  dcache_lane_sequencer dut (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .of_instruction_valid_i  (of_valid),
    .of_instruction_i        (of_instr),
    .of_mask_value_i         (of_mask),
    .of_thread_idx_i         (of_thread),
    .of_base_addr_i          (of_base),
    .of_stride_i             (of_stride),
    .of_ptr_vector_i         (of_ptr),
    .of_store_value_i        (of_store),
    .ls_ready_o              (ls_ready),
    .ls_instruction_valid_o  (ls_valid),
    .ls_instruction_o        (ls_instr),
    .ls_mask_value_o         (ls_mask),
    .ls_thread_idx_o         (ls_thread),
    .ls_request_addr_o       (ls_addr),
    .ls_store_value_o        (ls_store),
    .ls_lane_value_o         (ls_lane_value),
    .ls_lane_idx_o           (ls_lane_idx),
    .ls_last_lane_o          (ls_last),
    .wb_rollback_en_i        (wb_en),
    .wb_rollback_thread_idx_i(wb_thr),
    .wb_source_pipeline_i    (wb_src),
    .dbg_seq_active_o        (dbg_seq)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]          addr;
    int                   lane;
    logic [31:0]          val;
    logic                 last;
    logic                 seq;
    decoded_instruction_t instr;
    logic [NUM_LANES-1:0] mask;
    thread_idx_t          thread;
  } acc_t;

  acc_t exp_q[$];     // accesses still to be presented
  acc_t cur;          // access presented now
  bit   cur_v = 0;
  bit   took;         // upstream saw its instruction consumed this edge
  bit   rb_rand = 0;
  int   valid_run = 0;
  int   max_run = 0;

  function automatic bit model_is_seq(input memory_op_t t);
    return t inside {MEM_STRIDED, MEM_STRIDED_M, MEM_STRIDED_IM,
                     MEM_SCGATH, MEM_SCGATH_M, MEM_SCGATH_IM};
  endfunction

  // Expand the presented instruction into its list of expected accesses.
  task automatic model_expand();
    memory_op_t t;
    logic [NUM_LANES-1:0] act;
    int hi;
    acc_t a;
    t = of_instr.memory_access_type;
    a.instr = of_instr;
    a.mask = of_mask;
    a.thread = of_thread;
    if (!model_is_seq(t)) begin
      a.addr = of_base; a.lane = 0; a.val = of_store[0]; a.last = 1; a.seq = 0;
      exp_q.push_back(a);
    end else begin
      act = '1;
`ifdef DCACHE_SKIP_MASKED_LANES_EN
      if (t inside {MEM_STRIDED_M, MEM_STRIDED_IM, MEM_SCGATH_M, MEM_SCGATH_IM}) act = of_mask;
`endif
      hi = -1;
      for (int k = 0; k < NUM_LANES; k++) if (act[k]) hi = k;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (act[k]) begin
          a.addr = (t inside {MEM_STRIDED, MEM_STRIDED_M, MEM_STRIDED_IM}) ?
                   of_base + 32'(k) * of_stride : of_ptr[k];
          a.lane = k; a.val = of_store[k]; a.last = (k == hi); a.seq = 1;
          exp_q.push_back(a);
        end
      end
    end
  endtask

  // Model update for one rising edge, using the inputs seen at that edge.
  task automatic model_edge();
    bit rb, abort, drop, rdy;
    rb    = wb_en && (wb_src == PIPE_MEM);
    abort = rb && cur_v && cur.seq && (cur.thread == wb_thr);
    drop  = rb && (of_thread == wb_thr);
    rdy   = (exp_q.size() == 0);
    took  = of_valid && rdy;
    if (abort) begin
      exp_q.delete();
      cur_v = 0;
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      cur_v = 1;
    end else if (took && !drop) begin
      model_expand();
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        cur_v = 1;
      end else cur_v = 0;
    end else cur_v = 0;
  endtask

  task automatic check_outputs();
    check_eq("valid", 64'(ls_valid), 64'(cur_v));
    check_eq("dbg_seq", 64'(dbg_seq), 64'(cur_v && cur.seq));
    if (cur_v) begin
      check_eq("addr", 64'(ls_addr), 64'(cur.addr));
      check_eq("lane_idx", 64'(ls_lane_idx), 64'(cur.lane));
      check_eq("lane_value", 64'(ls_lane_value), 64'(cur.val));
      check_eq("last_lane", 64'(ls_last), 64'(cur.last));
      check_eq("instr", 64'(ls_instr), 64'(cur.instr));
      check_eq("mask", 64'(ls_mask), 64'(cur.mask));
      check_eq("thread", 64'(ls_thread), 64'(cur.thread));
    end
    if (ls_valid) valid_run++; else valid_run = 0;
    if (valid_run > max_run) max_run = valid_run;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    if (rb_rand) begin
      wb_en  = ($urandom_range(0, 11) == 0);
      wb_thr = thread_idx_t'($urandom_range(0, 3));
      wb_src = ($urandom_range(0, 3) == 0) ? PIPE_FLOAT_ARITH : PIPE_MEM;
    end
    check_eq("ready", 64'(ls_ready), 64'(exp_q.size() == 0));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  function automatic decoded_instruction_t mk_instr(input memory_op_t t);
    decoded_instruction_t d;
    d.is_memory_access = 1'b1;
    d.is_load = 1'($urandom_range(0, 1));
    d.memory_access_type = t;
    d.dest_reg = 6'($urandom_range(0, 63));
    return d;
  endfunction

  function automatic vector_t rand_vec();
    vector_t v;
    for (int i = 0; i < NUM_LANES; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic issue(input memory_op_t t, input thread_idx_t thr, input logic [NUM_LANES-1:0] m,
                       input scalar_t base, input scalar_t stride, input vector_t ptr, input vector_t st);
    int n;
    of_instr = mk_instr(t); of_thread = thr; of_mask = m;
    of_base = base; of_stride = stride; of_ptr = ptr; of_store = st;
    of_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!took && n < 64);
    if (!took) begin
      checks++; failures++;
      $display("FAIL issue_timeout: got waited=%0d expected accept", n);
    end
    of_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cur_v || exp_q.size() > 0) && n < 40) begin
      cycle();
      n++;
    end
    check_eq("drain_bound", 64'(n < 40), 64'(1));
  endtask

  task automatic run_to_lane(input int lane);
    int n;
    n = 0;
    while (!(cur_v && cur.lane == lane) && n < 40) begin
      cycle();
      n++;
    end
    check_eq("reach_lane", 64'(cur_v && cur.lane == lane), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vector_t pv;
    of_valid = 0; of_instr = '0; of_mask = '0; of_thread = '0;
    of_base = '0; of_stride = '0; of_ptr = '0; of_store = '0;
    wb_en = 0; wb_thr = '0; wb_src = PIPE_MEM;
    rst_n = 1'b0;
    #12;
    check_eq("rst_valid", 64'(ls_valid), 64'(0));
    check_eq("rst_addr", 64'(ls_addr), 64'(0));
    check_eq("rst_lane_idx", 64'(ls_lane_idx), 64'(0));
    check_eq("rst_last", 64'(ls_last), 64'(0));
    check_eq("rst_dbg", 64'(dbg_seq), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready", 64'(ls_ready), 64'(1));

    // Scalar load
    issue(MEM_L, 2'd0, 16'hFFFF, 32'h2004, 32'h0, rand_vec(), rand_vec());
    check_eq("scalar_addr", 64'(ls_addr), 64'h2004);
    drain();

    // Strided store, base 0x1000 stride 8
    issue(MEM_STRIDED, 2'd1, 16'hFFFF, 32'h1000, 32'd8, rand_vec(), rand_vec());
    drain();

    // Back-to-back scatters: 32 consecutive valid cycles
    for (int k = 0; k < NUM_LANES; k++) pv[k] = 32'h4000 + 32'h40 * k;
    max_run = 0;
    issue(MEM_SCGATH, 2'd2, 16'hFFFF, 32'h0, 32'h0, pv, rand_vec());
    issue(MEM_SCGATH, 2'd3, 16'h1234, 32'h0, 32'h0, pv, rand_vec());
    drain();
    check_eq("b2b_run", 64'(max_run), 64'(2 * NUM_LANES));

    // Address wrap
    issue(MEM_STRIDED, 2'd0, 16'hFFFF, 32'hFFFF_FFF8, 32'd4, rand_vec(), rand_vec());
    run_to_lane(2);
    check_eq("wrap_lane2", 64'(ls_addr), 64'h0);
    drain();

    // Matching rollback at lane 5
    issue(MEM_STRIDED_M, 2'd1, 16'hFFFF, 32'h8000, 32'd16, rand_vec(), rand_vec());
    run_to_lane(5);
    wb_en = 1; wb_thr = 2'd1; wb_src = PIPE_MEM;
    cycle();
    wb_en = 0;
    check_eq("rb_valid", 64'(ls_valid), 64'(0));
    check_eq("rb_ready", 64'(ls_ready), 64'(1));
    drain();

    // Non-matching thread and non-memory pipeline rollbacks have no effect
    issue(MEM_SCGATH_IM, 2'd2, 16'h00FF, 32'h0, 32'h0, rand_vec(), rand_vec());
    run_to_lane(5);
    wb_en = 1; wb_thr = 2'd3; wb_src = PIPE_MEM;
    cycle();
    wb_thr = 2'd2; wb_src = PIPE_INT_ARITH;
    cycle();
    wb_en = 0; wb_src = PIPE_MEM;
    drain();

    // Masked scatter 0x8001 and mask 0
    issue(MEM_SCGATH_M, 2'd0, 16'h8001, 32'h0, 32'h0, rand_vec(), rand_vec());
    drain();
    issue(MEM_SCGATH_M, 2'd0, 16'h0000, 32'h0, 32'h0, rand_vec(), rand_vec());
    drain();

    // Randomized instructions with random rollbacks
    rb_rand = 1;
    for (int i = 0; i < 250; i++) begin
      memory_op_t t;
      logic [NUM_LANES-1:0] m;
      repeat ($urandom_range(0, 1)) cycle();
      t = memory_op_t'($urandom_range(0, 14));
      case ($urandom_range(0, 3))
        0: m = 16'h0000;
        1: m = 16'h8001;
        default: m = 16'($urandom);
      endcase
      issue(t, thread_idx_t'($urandom_range(0, 3)), m, $urandom,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom,
            rand_vec(), rand_vec());
    end
    rb_rand = 0;
    wb_en = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_lane_sequencer.md
Name: dcache_lane_sequencer

Overview:
- Memory-pipeline stage placed directly upstream of the dcache tag/data stages. It accepts decoded memory instructions from operand fetch.
- Scalar and block-vector accesses pass through with one register stage.
- Strided and scatter/gather vector accesses are expanded into one per-lane access per cycle. Each lane access carries its own address, lane index and lane store word.
- Upstream is back-pressured while a sequence is in progress. Rollback from writeback cancels a sequence mid-flight.

Parameters:
NUM_LANES, `VECTOR_LANES (16), lanes per vector; also the iteration count.
LANE_IDX_W, $clog2(NUM_LANES) (4), width of the lane counter and lane index.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
of_instruction_valid  in  1  upstream instruction present
of_instruction  in  decoded_instruction_t  decoded instruction
of_mask_value  in  NUM_LANES  lane mask
of_thread_idx  in  thread_idx_t  issuing thread
of_base_addr  in  scalar_t  scalar/block address, or strided base
of_stride  in  scalar_t  byte stride for strided ops
of_ptr_vector  in  vector_t  per-lane pointers for scatter/gather
of_store_value  in  vector_t  store data
ls_ready  out  1  block can accept an instruction this cycle
ls_instruction_valid  out  1  output access valid
ls_instruction  out  decoded_instruction_t  instruction (registered)
ls_mask_value  out  NUM_LANES  mask (registered)
ls_thread_idx  out  thread_idx_t  thread (registered)
ls_request_addr  out  scalar_t  access address
ls_store_value  out  vector_t  full store vector (block ops)
ls_lane_value  out  scalar_t  store word for the current lane
ls_lane_idx  out  LANE_IDX_W  current lane (0 for non-sequenced ops)
ls_last_lane  out  1  final access of this instruction
wb_rollback_en  in  1  rollback request
wb_rollback_thread_idx  in  thread_idx_t  thread being rolled back
wb_source_pipeline  in  pipeline_sel_t  pipeline that raised the rollback

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, lane counter=0.
  - All registered outputs 0. ls_ready=1 once reset deasserts.
- Accept condition: of_instruction_valid && ls_ready. If ls_ready=0, inputs are ignored and upstream must hold them.
- States: IDLE and SEQ.
- IDLE, accept of a non-sequenced op (scalar, block, control register):
  - Next cycle: ls_instruction_valid=1, ls_request_addr=of_base_addr, ls_lane_idx=0, ls_last_lane=1, ls_lane_value=of_store_value[0].
  - Latency 1. State stays IDLE.
- IDLE, accept of a sequenced op (MEM_STRIDED*, MEM_SCGATH*):
  - Latch instruction, mask, thread, stride, pointers and store vector. Go to SEQ.
  - The lane 0 access is emitted the next cycle.
- SEQ, cycle k (k = 0..NUM_LANES-1), emits lane k:
  - ls_instruction_valid=1, ls_lane_idx=k, ls_lane_value=store[k].
  - Strided: addr = base + k*stride, computed by an accumulator (addr += stride each cycle) with 32-bit wrap-around, no overflow flag.
  - Scatter/gather: addr = ptr[k].
  - Alignment is not checked here.
- ls_last_lane=1 when k=NUM_LANES-1.
- ls_ready = (state==IDLE) || (state==SEQ && k==NUM_LANES-1). A new instruction can therefore be accepted in the last-lane cycle, so there is no bubble between back-to-back ops.
- After the last lane: return to IDLE, or stay in SEQ with a reset counter if a sequenced op was accepted that cycle.
- Mask is forwarded unchanged. Masked-off lanes are still emitted unless the Optional Feature is enabled; the downstream stage gates the write.
- Rollback (wb_rollback_en && wb_source_pipeline==PIPE_MEM && wb_rollback_thread_idx matches):
  - Matching in-flight sequence thread: the sequence is aborted. Next cycle ls_instruction_valid=0, state=IDLE, ls_ready=1.
  - Matching thread of the instruction being accepted that cycle: that instruction is dropped.
  - Non-matching thread: no effect.
- Rollback and the last lane in the same cycle: the sequence is still aborted. No instruction is accepted that cycle.

Optional Feature:
- Macro: DCACHE_SKIP_MASKED_LANES_EN.
- Defined:
  - Only active lanes are emitted. The effective mask is of_mask_value for *_M/*_IM types and all-ones otherwise.
  - A priority encoder selects the next active lane each cycle. Stride addressing uses base + lane*stride via a multiplier or shift-add, not the accumulator.
  - ls_last_lane marks the highest active lane. ls_ready uses the same condition.
  - A sequenced op with an effective mask of 0 emits nothing and consumes one cycle.
- Undefined: all NUM_LANES lanes are emitted as described above.

Decomposition:
- Shared defines package holds:
  - decoded_instruction_t, thread_idx_t, scalar_t, vector_t, pipeline_sel_t and the MEM_* access-type enum.
  - A new helper predicate is_sequenced_access(memory_access_type).
- One sub-module: lane_priority_select (next-active-lane encoder), instantiated only under DCACHE_SKIP_MASKED_LANES_EN.

Test Plan:
- Scalar load, addr 0x2004 -> one cycle later valid=1, addr=0x2004, lane_idx=0, last_lane=1, ready never drops.
- Strided store, base 0x1000, stride 8 -> 16 accesses at 0x1000..0x1078, lane_value=store[k], ready low 15 cycles, last_lane on 0x1078.
- Scatter with ptr[k]=0x4000+0x40*k followed back-to-back by a second scatter -> 32 consecutive valid cycles with no gap.
- Strided, base 0xFFFFFFF8, stride 4 -> lanes 0..3 give 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
- Rollback for the matching thread while lane 5 is output -> valid=0 from the next cycle, ready=1. Rollback for a different thread -> all 16 lanes complete.
- With DCACHE_SKIP_MASKED_LANES_EN, MEM_SCGATH_M, mask 0x8001 -> exactly 2 accesses (lanes 0 and 15), last_lane on lane 15. Mask 0 -> none.
